// File: rtl/ltc2308_sampler.sv
// LTC2308 SPI ADC sampler: periodic conversions on a selectable single-ended channel,
// optional 2^AVG_LOG2 box averaging, held 12-bit result with a one-cycle valid strobe.
module ltc2308_sampler #(
  parameter int unsigned SCK_DIV       = 2,
  parameter int unsigned CONVST_CYCLES = 2,
  parameter int unsigned CONV_CYCLES   = 80,
  parameter int unsigned SAMPLE_PERIOD = 500,
  parameter int unsigned AVG_LOG2      = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  channel,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic [11:0] dout,
  output logic [2:0]  dout_ch,
  output logic        dout_valid
);

  localparam int unsigned T01  = (CONVST_CYCLES > CONV_CYCLES) ? CONVST_CYCLES : CONV_CYCLES;
  localparam int unsigned TMAX = (T01 > 2 * SCK_DIV) ? T01 : 2 * SCK_DIV;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned PW   = $clog2(SAMPLE_PERIOD + 1);
  localparam int unsigned AW   = 12 + AVG_LOG2;
  localparam int unsigned NW   = AVG_LOG2 + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONVST = 3'd1;
  localparam logic [2:0] S_CONV   = 3'd2;
  localparam logic [2:0] S_SHIFT  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]    state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [3:0]    bitn, bitn_nx;
  logic [PW-1:0] pcnt;
  logic          pending;
  logic          tick_c, start_c;
  logic [2:0]    cfg_ch, res_ch, acc_ch;
  logic          rv;
  logic [11:0]   sreg;
  logic [11:0]   sdi_word_c;
  logic [AW-1:0] acc, acc_sum_c;
  logic [NW-1:0] acc_n, acc_n_sum_c;
  logic          restart_c, full_c;

  assign tick_c  = (pcnt == PW'(SAMPLE_PERIOD - 1));
  assign start_c = (state == S_IDLE) && (tick_c || pending);

  // Config word S/D, O/S, S1, S0, UNI, SLP followed by zeros for the rest of the frame
  assign sdi_word_c = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], 1'b1, 7'b0};

  // Box average: a channel change drops any partial sum
  assign restart_c   = (acc_ch != res_ch);
  assign acc_sum_c   = (restart_c ? '0 : acc) + AW'(sreg);
  assign acc_n_sum_c = (restart_c ? '0 : acc_n) + NW'(1);
  assign full_c      = (acc_n_sum_c == NW'(1 << AVG_LOG2));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      tcnt  <= '0;
      bitn  <= '0;
    end else begin
      state <= state_nx;
      tcnt  <= tcnt_nx;
      bitn  <= bitn_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    bitn_nx  = bitn;
    case (state)
      S_IDLE: begin
        if (start_c) begin
          state_nx = S_CONVST;
          tcnt_nx  = '0;
        end
      end
      S_CONVST: begin
        if (tcnt == TW'(CONVST_CYCLES - 1)) begin
          state_nx = S_CONV;
          tcnt_nx  = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_CONV: begin
        if (tcnt == TW'(CONV_CYCLES - 1)) begin
          state_nx = S_SHIFT;
          tcnt_nx  = '0;
          bitn_nx  = '0;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_SHIFT: begin
        if (tcnt == TW'(2 * SCK_DIV - 1)) begin
          tcnt_nx = '0;
          if (bitn == 4'd11) begin
            state_nx = S_DONE;
          end else begin
            bitn_nx = bitn + 4'd1;
          end
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Sample-period timer and one-deep pending request
  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt    <= '0;
      pending <= 1'b0;
    end else begin
      pcnt <= tick_c ? '0 : pcnt + PW'(1);
      if (start_c) begin
        pending <= 1'b0;
      end else if (tick_c && (state != S_IDLE)) begin
        pending <= 1'b1;
      end
    end
  end

  // ADC pins are registered from the next state so they line up with state entry
  always_ff @(posedge clk) begin
    if (reset) begin
      adc_convst <= 1'b0;
      adc_sck    <= 1'b0;
      adc_sdi    <= 1'b0;
      cfg_ch     <= '0;
      sreg       <= '0;
    end else begin
      adc_convst <= (state_nx == S_CONVST);
      adc_sck    <= (state_nx == S_SHIFT) && (tcnt_nx >= TW'(SCK_DIV));
      adc_sdi    <= (state_nx == S_SHIFT) && sdi_word_c[4'(4'd11 - bitn_nx)];
      if (start_c) begin
        cfg_ch <= channel;
      end
      if ((state == S_SHIFT) && (tcnt == TW'(SCK_DIV - 1))) begin
        sreg <= {sreg[10:0], adc_sdo};
      end
    end
  end

  // Result ownership: the data read in a frame belongs to the previous frame's config
  always_ff @(posedge clk) begin
    if (reset) begin
      res_ch     <= '0;
      rv         <= 1'b0;
      acc        <= '0;
      acc_n      <= '0;
      acc_ch     <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (state == S_DONE) begin
        if (rv) begin
          acc_ch <= res_ch;
          if (full_c) begin
            dout       <= 12'(acc_sum_c >> AVG_LOG2);
            dout_ch    <= res_ch;
            dout_valid <= 1'b1;
            acc        <= '0;
            acc_n      <= '0;
          end else begin
            acc   <= acc_sum_c;
            acc_n <= acc_n_sum_c;
          end
        end
        res_ch <= cfg_ch;
        rv     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ltc2308_sampler.sv
// Bench for ltc2308_sampler: two instances (direct output at 500-cycle period, 4x averaging
// back-to-back), each with an LTC2308 pin model and a scoreboard-driven output monitor.
module tb_ltc2308_sampler;

  localparam int unsigned SCK_DIV       = 2;
  localparam int unsigned CONVST_CYCLES = 2;
  localparam int unsigned CONV_CYCLES   = 80;
  localparam int unsigned FRAME         = CONVST_CYCLES + CONV_CYCLES + 24 * SCK_DIV + 1;

  typedef struct packed {
    logic [11:0] v;
    logic [2:0]  ch;
    logic [31:0] cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] channel [2];
  int         checks;
  int         failures;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h at %0t", name, inst, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int unsigned AVG = (g == 0) ? 0 : 2;
    localparam int unsigned SP  = (g == 0) ? 500 : 50;
    localparam int unsigned PER = (SP > FRAME) ? SP : FRAME + 1;

    logic        convst, sck, sdi, dv;
    logic        sdo = 1'b0;
    logic [11:0] dout;
    logic [2:0]  dout_ch;

    logic [11:0] val [8];
    logic [11:0] dq  [$];
    logic [11:0] obs [$];
    exp_t        sb  [$];
    int          rises = 0;

    ltc2308_sampler #(
      .SCK_DIV(SCK_DIV), .CONVST_CYCLES(CONVST_CYCLES), .CONV_CYCLES(CONV_CYCLES),
      .SAMPLE_PERIOD(SP), .AVG_LOG2(AVG)
    ) dut (
      .clk(clk), .reset(reset), .channel(channel[g]),
      .adc_convst(convst), .adc_sck(sck), .adc_sdi(sdi), .adc_sdo(sdo),
      .dout(dout), .dout_ch(dout_ch), .dout_valid(dv)
    );

    // ADC pin model plus reference: frame N shifts out the conversion configured in frame N-1
    initial begin
      int          cyc = 0, cv_len = 0, cv_fall = 0, cv_rise = 0, sck_rise = 0, sck_fall = 0;
      int          acc = 0, acc_n = 0;
      bit          have_cv = 0, have_prev = 0;
      logic        p_sck = 1'b0, p_cv = 1'b0;
      logic [2:0]  cfg_exp = '0, prev_ch = '0, acc_ch = '0, adc_cfg_ch = '0;
      logic [11:0] sdi_bits = '0, data = '0;
      logic [14:0] last = '0;
      exp_t        e;
      forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
          chk("reset_outputs", g, {convst, sck, sdi, dv, dout_ch, dout}, 0);
          rises = 0; have_cv = 0; have_prev = 0; acc = 0; acc_n = 0; last = '0;
          sdo = 1'b0;
          sb.delete();
        end else begin
          if (convst && !p_cv) begin
            if (have_cv) begin
              chk("convst_period", g, cyc - cv_rise, PER);
              chk("sck_pulses", g, rises, 12);
            end
            have_cv = 1; cv_rise = cyc; cv_len = 0; rises = 0;
            cfg_exp = channel[g];
            data = (dq.size() > 0) ? dq.pop_front() : val[adc_cfg_ch];
            sdo = data[11];
          end
          if (convst) cv_len++;
          if (!convst && p_cv) begin
            chk("convst_width", g, cv_len, CONVST_CYCLES);
            cv_fall = cyc;
          end
          if (sck && !p_sck) begin
            if (rises == 0) chk("conv_wait", g, cyc - cv_fall, CONV_CYCLES + SCK_DIV);
            else            chk("sck_low", g, cyc - sck_fall, SCK_DIV);
            if (rises < 12) sdi_bits[4'(11 - rises)] = sdi;
            rises++;
            sdo = (rises < 12) ? data[4'(11 - rises)] : 1'b0;
            sck_rise = cyc;
          end
          if (!sck && p_sck) begin
            chk("sck_high", g, cyc - sck_rise, SCK_DIV);
            sck_fall = cyc;
            if (rises == 12) begin
              chk("sdi_word", g, sdi_bits, {1'b1, cfg_exp[0], cfg_exp[2], cfg_exp[1], 1'b1, 7'b0});
              adc_cfg_ch = {sdi_bits[9], sdi_bits[8], sdi_bits[10]};
              if (have_prev) begin
                if (acc_n != 0 && acc_ch != prev_ch) begin
                  acc = 0; acc_n = 0;
                end
                acc += int'(data); acc_n++; acc_ch = prev_ch;
                if (acc_n == (1 << AVG)) begin
                  e.v = 12'(acc / (1 << AVG)); e.ch = prev_ch; e.cyc = 32'(cyc + 1);
                  sb.push_back(e);
                  acc = 0; acc_n = 0;
                end
              end
              prev_ch = cfg_exp;
              have_prev = 1;
            end
          end
          if (dv) begin
            if (sb.size() == 0) begin
              chk("unexpected_valid", g, 1, 0);
            end else begin
              e = sb.pop_front();
              chk("dout", g, dout, e.v);
              chk("dout_ch", g, dout_ch, e.ch);
              chk("valid_cycle", g, cyc, e.cyc);
            end
            obs.push_back(dout);
            last = {dout_ch, dout};
          end else begin
            chk("dout_hold", g, {dout_ch, dout}, last);
          end
        end
        p_sck = sck;
        p_cv  = convst;
      end
    end
  end

  initial begin
    int n0;
    checks = 0; failures = 0;
    reset = 1'b1;
    channel[0] = 3'd0; channel[1] = 3'd0;
    for (int i = 0; i < 8; i++) begin
      u[0].val[i] = 12'($urandom);
      u[1].val[i] = 12'($urandom);
    end
    u[0].val[0] = 12'hA5C;
    repeat (4) @(negedge clk);
    // first averaged frame after reset is discarded, then two groups of four
    u[1].dq.push_back(12'($urandom));
    u[1].dq.push_back(12'h100); u[1].dq.push_back(12'h101);
    u[1].dq.push_back(12'h102); u[1].dq.push_back(12'h104);
    repeat (4) u[1].dq.push_back(12'hFFF);
    reset = 1'b0;

    for (int k = 0; k < 3000 && u[0].obs.size() < 1; k++) @(negedge clk);
    chk("first_dout", 0, (u[0].obs.size() > 0) ? int'(u[0].obs[0]) : -1, 'hA5C);
    for (int k = 0; k < 3000 && u[1].obs.size() < 2; k++) @(negedge clk);
    chk("avg_first", 1, (u[1].obs.size() > 0) ? int'(u[1].obs[0]) : -1, 'h101);
    chk("avg_second", 1, (u[1].obs.size() > 1) ? int'(u[1].obs[1]) : -1, 'hFFF);

    channel[0] = 3'd5; channel[1] = 3'd5;
    repeat (1200) @(negedge clk);

    // mid-stream channel change 0 -> 3 with distinct per-channel values
    for (int g = 0; g < 2; g++) begin
      if (g == 0) begin u[0].val[0] = 12'h200; u[0].val[3] = 12'h300; end
      else        begin u[1].val[0] = 12'h200; u[1].val[3] = 12'h300; end
    end
    channel[0] = 3'd0; channel[1] = 3'd0;
    repeat (1500) @(negedge clk);
    channel[0] = 3'd3; channel[1] = 3'd3;
    repeat (1500) @(negedge clk);

    repeat (16) begin
      if ($urandom_range(0, 1) == 1) channel[0] = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) channel[1] = 3'($urandom_range(0, 7));
      u[0].val[$urandom_range(0, 7)] = 12'($urandom);
      u[1].val[$urandom_range(0, 7)] = 12'($urandom);
      repeat ($urandom_range(100, 400)) @(negedge clk);
    end

    // reset landing in SHIFT bit 6 of dut0
    for (int k = 0; k < 1000 && u[0].rises != 6; k++) @(negedge clk);
    chk("reach_bit6", 0, u[0].rises, 6);
    repeat (2) @(negedge clk);
    n0 = u[0].obs.size();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (1600) @(negedge clk);
    chk("post_reset_outputs", 0, u[0].obs.size() - n0, 1);

    for (int k = 0; k < 20 && (u[0].sb.size() != 0 || u[1].sb.size() != 0); k++) @(negedge clk);
    chk("sb_drain", 0, u[0].sb.size(), 0);
    chk("sb_drain", 1, u[1].sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ltc2308_sampler.md
Name: ltc2308_sampler

Overview:
- Upstream feeder for the ADC test-pattern video block; drives the DE10-Nano LTC2308 SPI ADC and produces the 12-bit `adc_value` that block displays.
- Runs periodic conversions on a selectable single-ended channel and optionally box-averages 2^AVG_LOG2 samples.
- Presents a held 12-bit result with a one-cycle valid strobe.

Parameters:
- SCK_DIV, 2: clk cycles per SCK half-period (SCK = clk/(2*SCK_DIV)); must be ≥1.
- CONVST_CYCLES, 2: clk cycles CONVST is held high.
- CONV_CYCLES, 80: clk cycles waited after CONVST falls before shifting (≥ tCONV 1.6 us).
- SAMPLE_PERIOD, 500: clk cycles between conversion starts (100 ksps at 50 MHz).
- AVG_LOG2, 0: log2 of samples averaged per output; range 0..4.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous active-high reset.
- channel, in, 3: requested single-ended input channel.
- adc_convst, out, 1: LTC2308 CONVST.
- adc_sck, out, 1: SPI clock; idles low.
- adc_sdi, out, 1: config bits to ADC.
- adc_sdo, in, 1: result bits from ADC.
- dout, out, 12: averaged result; held between updates.
- dout_ch, out, 3: channel that `dout` belongs to.
- dout_valid, out, 1: one-cycle strobe when `dout` and `dout_ch` update.

Behaviour:
- Interface: one clock, `clk`; `reset` is synchronous and active-high.
- Reset: all outputs 0. Also cleared: FSM = IDLE, period counter, pending flag, accumulator, sample count, and the result-valid flag (`rv`).
  - Reset applies on the next edge from any state, including mid-SHIFT; SCK, CONVST and SDI drop to 0 on that edge.
- Period counter: counts 0..SAMPLE_PERIOD-1 and wraps; the wrap produces `tick`.
  - `tick` in IDLE starts a frame.
  - `tick` while busy sets `pending` (one deep; further ticks are lost).
  - On returning to IDLE with `pending` set, the next frame starts on the following cycle and `pending` clears.
- FSM, IDLE -> CONVST -> CONV -> SHIFT -> DONE -> IDLE:
  - CONVST: `adc_convst`=1 for CONVST_CYCLES.
    - On entry, latch `cfg_ch`=`channel`.
    - Build the config word, MSB first: S/D=1, O/S=cfg_ch[0], S1=cfg_ch[2], S0=cfg_ch[1], UNI=1, SLP=0.
  - CONV: `adc_convst`=0; wait CONV_CYCLES.
  - SHIFT: 12 bit-periods of 2*SCK_DIV cycles each.
    - SCK is low for the first SCK_DIV cycles and high for the second.
    - `adc_sdi` presents config bit k (k=0..5, then 0) during the low half.
    - `adc_sdo` is registered into a 12-bit shift register, MSB first, on the cycle SCK rises.
    - SCK is returned low at exit.
  - DONE: one cycle; result processing as below.
- Result ownership:
  - LTC2308 returns the conversion configured in the previous frame.
  - `res_ch` holds the `cfg_ch` of the previous frame; `rv`=1 once any frame has completed since reset.
  - In DONE:
    - If `rv`=0, discard the result.
    - Otherwise accumulate the result under `res_ch`.
    - Then `res_ch`<=`cfg_ch` and `rv`<=1.
- Averaging:
  - Accumulator is 12+AVG_LOG2 bits, unsigned, no overflow possible.
  - If `res_ch` differs from the accumulator's channel, restart: acc = result, count = 1.
  - When count reaches 2^AVG_LOG2:
    - `dout`<=acc>>AVG_LOG2 (truncating).
    - `dout_ch`<=`res_ch`.
    - `dout_valid`=1 for exactly one cycle, the cycle after DONE.
    - acc and count clear.
  - AVG_LOG2=0: every accepted result is output directly.
- Latency: `dout_valid` rises 1 cycle after DONE. `channel` changes take effect at the next CONVST entry; first output for the new channel comes from the frame after that.
- Frame length = CONVST_CYCLES + CONV_CYCLES + 24*SCK_DIV + 1. If SAMPLE_PERIOD is smaller, frames run back-to-back via `pending`.

Test Plan:
- Reset, then ADC model returning 0xA5C on `channel`=0 -> no `dout_valid` in frame 1; frame 2 gives `dout`=0xA5C, `dout_ch`=0, `dout_valid` high exactly 1 cycle; all outputs 0 during reset.
- `channel`=5 -> SDI bit sequence on SCK rises is 1,1,1,0,1,0, then 0 ×6; 12 SCK pulses per frame, each 2 cycles high / 2 low; CONVST high 2 cycles; SCK not toggling until 80 cycles after CONVST falls.
- Default parameters -> CONVST rising edges exactly 500 cycles apart over 10 frames; with SAMPLE_PERIOD=50 -> frames back-to-back, 1 idle cycle between DONE and next CONVST.
- AVG_LOG2=2, model returns 0x100,0x101,0x102,0x104 -> single `dout_valid` with `dout`=0x101; next 4 samples all 0xFFF -> `dout`=0xFFF.
- `channel` 0->3 mid-stream, model returns 0x200 for ch0 and 0x300 for ch3 -> the frame after the change still outputs 0x200 with `dout_ch`=0, the next outputs 0x300 with `dout_ch`=3; with AVG_LOG2=2 the partial ch0 accumulation is dropped and no mixed average appears.
- Assert `reset` during SHIFT bit 6 -> next edge: `adc_sck`=0, `adc_convst`=0, `adc_sdi`=0, no `dout_valid`; after release, the first completed frame is discarded and the second produces valid data.
